// File: rtl/shifter_pipe.sv
//------------------------------------------------------------------------------
// Module   : shifter_pipe
// Purpose  : Pipelined barrel shifter (logical/fill/rotate, both directions)
//            with valid/ready flow control and a pass-through tag.
//            Optional flags (out_zero, out_carry): define SHIFTER_PIPE_FLAGS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shifter_pipe #(
  parameter int N      = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_a,
  input  logic [$clog2(N)-1:0] in_b,
  input  logic                 in_rot,
  input  logic                 in_left,
  input  logic                 in_sign,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic [TAG_W-1:0]     out_tag
`ifdef SHIFTER_PIPE_FLAGS_EN
  ,
  output logic                 out_zero,
  output logic                 out_carry
`endif
);

  localparam int L = $clog2(N);

  // Index 0 is the input port side; index k+1 is the output of slice k.
  logic             w_v     [STAGES+1];
  logic             w_rdy   [STAGES+1];
  logic [N-1:0]     w_data  [STAGES+1];
  logic [L-1:0]     w_b     [STAGES+1];
  logic             w_rot   [STAGES+1];
  logic             w_left  [STAGES+1];
  logic             w_sign  [STAGES+1];
  logic [TAG_W-1:0] w_tag   [STAGES+1];
  logic             w_carry [STAGES+1];

  function automatic logic [N-1:0] f_shift(
    input logic [N-1:0] d,
    input logic [L-1:0] b,
    input logic         rot,
    input logic         left,
    input logic         sign,
    input int           lo,
    input int           hi
  );
    logic [N-1:0] r;
    logic [N-1:0] fill;
    r    = d;
    fill = '0;
    for (int i = 0; i < L; i++) begin
      if (i >= lo && i <= hi && b[i]) begin
        if (left) begin
          fill = rot ? (r >> (N - (1 << i))) : ({N{sign}} >> (N - (1 << i)));
          r    = (r << (1 << i)) | fill;
        end else begin
          fill = rot ? (r << (N - (1 << i))) : ({N{sign}} << (N - (1 << i)));
          r    = (r >> (1 << i)) | fill;
        end
      end
    end
    return r;
  endfunction

  assign w_v[0]    = in_valid;
  assign w_data[0] = in_a;
  assign w_b[0]    = in_b;
  assign w_rot[0]  = in_rot;
  assign w_left[0] = in_left;
  assign w_sign[0] = in_sign;
  assign w_tag[0]  = in_tag;

  // Last bit shifted out is the same source bit for rotate and fill modes.
  logic [L-1:0] w_neg_b;
  logic [L-1:0] w_b_m1;
  assign w_neg_b = L'(0) - in_b;
  assign w_b_m1  = in_b - L'(1);

  always_comb begin
    w_carry[0] = 1'b0;
    if (in_b != '0) begin
      w_carry[0] = in_left ? in_a[w_neg_b] : in_a[w_b_m1];
    end
  end

  assign w_rdy[STAGES] = out_ready;
  assign in_ready      = w_rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    localparam int LO = (k * L) / STAGES;
    localparam int HI = ((k + 1) * L) / STAGES - 1;

    logic             r_v;
    logic [N-1:0]     r_data;
    logic [L-1:0]     r_b;
    logic             r_rot;
    logic             r_left;
    logic             r_sign;
    logic [TAG_W-1:0] r_tag;
    logic [N-1:0]     w_res;

    assign w_rdy[k] = !w_v[k+1] | w_rdy[k+1];
    assign w_res    = f_shift(w_data[k], w_b[k], w_rot[k], w_left[k], w_sign[k], LO, HI);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v    <= 1'b0;
        r_data <= '0;
        r_b    <= '0;
        r_rot  <= 1'b0;
        r_left <= 1'b0;
        r_sign <= 1'b0;
        r_tag  <= '0;
      end else if (w_rdy[k]) begin
        r_v <= w_v[k];
        if (w_v[k]) begin
          r_data <= w_res;
          r_b    <= w_b[k];
          r_rot  <= w_rot[k];
          r_left <= w_left[k];
          r_sign <= w_sign[k];
          r_tag  <= w_tag[k];
        end
      end
    end

    assign w_v[k+1]    = r_v;
    assign w_data[k+1] = r_data;
    assign w_b[k+1]    = r_b;
    assign w_rot[k+1]  = r_rot;
    assign w_left[k+1] = r_left;
    assign w_sign[k+1] = r_sign;
    assign w_tag[k+1]  = r_tag;

`ifdef SHIFTER_PIPE_FLAGS_EN
    logic r_carry;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_carry <= 1'b0;
      end else if (w_rdy[k] && w_v[k]) begin
        r_carry <= w_carry[k];
      end
    end
    assign w_carry[k+1] = r_carry;

    if (k == STAGES - 1) begin : g_zero
      // Registered rather than decoded from out_data so it resets to 0.
      logic r_zero;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_zero <= 1'b0;
        end else if (w_rdy[k] && w_v[k]) begin
          r_zero <= (w_res == '0);
        end
      end
      assign out_zero = r_zero;
    end
`else
    assign w_carry[k+1] = w_carry[k];
`endif
  end

  assign out_valid = w_v[STAGES];
  assign out_data  = w_data[STAGES];
  assign out_tag   = w_tag[STAGES];

`ifdef SHIFTER_PIPE_FLAGS_EN
  assign out_carry = w_carry[STAGES];
`endif

  logic w_unused;
  assign w_unused = ^{w_b[STAGES], w_rot[STAGES], w_left[STAGES], w_sign[STAGES],
                      w_carry[STAGES]};

endmodule

`default_nettype wire

// File: tb/tb_shifter_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_shifter_pipe
// Purpose  : Self-checking bench for shifter_pipe (N=8, STAGES=3, TAG_W=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shifter_pipe;
  localparam int N      = 8;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid, in_ready;
  logic [N-1:0]     in_a;
  logic [2:0]       in_b;
  logic             in_rot, in_left, in_sign;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [N-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
`ifdef SHIFTER_PIPE_FLAGS_EN
  logic             out_zero, out_carry;
`endif

  shifter_pipe #(.N(N), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rot(in_rot), .in_left(in_left),
    .in_sign(in_sign), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
`ifdef SHIFTER_PIPE_FLAGS_EN
    , .out_zero(out_zero), .out_carry(out_carry)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] t;
    logic       c;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic last_ov, last_ir;
  int   lat;

  // Reference: shift of the whole amount at once using plain integer arithmetic.
  function automatic logic [7:0] ref_shift(logic [7:0] a, int b, logic rot, logic left, logic sign);
    int unsigned x, r;
    x = a;
    if (b == 0) return a;
    if (left) r = rot ? ((x << b) | (x >> (8 - b))) : ((x << b) | (sign ? ((1 << b) - 1) : 0));
    else      r = rot ? ((x >> b) | (x << (8 - b))) : ((x >> b) | (sign ? (255 & ~(255 >> b)) : 0));
    return r[7:0];
  endfunction

  function automatic logic ref_carry(logic [7:0] a, int b, logic left);
    if (b == 0) return 1'b0;
    return left ? a[8 - b] : a[b - 1];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(logic [7:0] a, logic [2:0] b, logic rot, logic left, logic sign, logic [3:0] t);
    in_valid = 1'b1; in_a = a; in_b = b; in_rot = rot; in_left = left; in_sign = sign; in_tag = t;
  endtask

  task automatic rand_op();
    offer(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
  endtask

  // One clock: sample at the falling edge, score outputs, record acceptance.
  task automatic cycle();
    @(negedge clk);
    last_ov = out_valid;
    last_ir = in_ready;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        chk("out_data", 32'(out_data), 32'(q[0].d));
        chk("out_tag", 32'(out_tag), 32'(q[0].t));
`ifdef SHIFTER_PIPE_FLAGS_EN
        chk("out_carry", 32'(out_carry), 32'(q[0].c));
        chk("out_zero", 32'(out_zero), 32'(q[0].d == 8'h00));
`endif
        if (out_ready) void'(q.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(exp_t'{ref_shift(in_a, int'(in_b), in_rot, in_left, in_sign), in_tag,
                         ref_carry(in_a, int'(in_b), in_left)});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; out_ready = 1; in_a = 0; in_b = 0; in_rot = 0; in_left = 0; in_sign = 0; in_tag = 0;

    // Reset state while rst is held
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Left logical, latency measurement
    offer(8'hB5, 3'd3, 1'b0, 1'b1, 1'b0, 4'd5);
    cycle();
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      cycle();
      if (last_ov) lat = i;
    end
    chk("latency", 32'(lat), 32'd3);

    // Right fill-1 and rotate right, plus b=0 in two modes
    offer(8'h80, 3'd7, 1'b0, 1'b0, 1'b1, 4'd1); cycle();
    offer(8'h81, 3'd1, 1'b1, 1'b0, 1'b0, 4'd2); cycle();
    offer(8'h5A, 3'd0, 1'b1, 1'b1, 1'b1, 4'd3); cycle();
    offer(8'hC3, 3'd0, 1'b0, 1'b0, 1'b1, 4'd4); cycle();
    in_valid = 1'b0;
    repeat (5) cycle();

    // Back-to-back: 8 ops, results on 8 consecutive cycles
    for (int j = 0; j < 13; j++) begin
      if (j < 8) rand_op(); else in_valid = 1'b0;
      cycle();
      if (j < 8) chk("b2b_in_ready", 32'(last_ir), 32'd1);
      chk("b2b_out_valid", 32'(last_ov), 32'(j >= 3 && j <= 10));
    end

    // Backpressure: three accepted, fourth refused until drain starts
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      rand_op();
      cycle();
      chk("bp_in_ready", 32'(last_ir), 32'(j < 3));
    end
    repeat (3) begin
      cycle();
      chk("bp_hold_in_ready", 32'(last_ir), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_accept", 32'(last_ir), 32'd1);
    in_valid = 1'b0;
    repeat (6) cycle();
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Bubble collapse behind a stalled head
    out_ready = 1'b0;
    rand_op(); cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    rand_op(); cycle();
    chk("bubble_accept", 32'(last_ir), 32'd1);
    chk("bubble_head_held", 32'(last_ov), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) cycle();
    chk("bubble_drained", 32'(q.size()), 32'd0);

    // Random traffic with random backpressure
    for (int j = 0; j < 300; j++) begin
      if ($urandom_range(3, 0) != 0) rand_op(); else in_valid = 1'b0;
      out_ready = 1'($urandom_range(2, 0) != 0);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) cycle();
    chk("random_drained", 32'(q.size()), 32'd0);

    // Asynchronous reset with a full pipeline
    out_ready = 1'b0;
    repeat (3) begin rand_op(); cycle(); end
    in_valid = 1'b0;
    cycle();
    chk("rst_pre_full", 32'(last_ov), 32'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_tag", 32'(out_tag), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) begin
      cycle();
      chk("post_rst_no_stale", 32'(last_ov), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
